// File: rtl/boot_loader_if.sv
// Boot-loader bus bundle: boot ROM read port plus downstream valid/ready write port.
// The master side is the boot loader; the slave side is the ROM/memory pair.
interface boot_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  rom_rd_ena;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  mem_wr_valid;
    logic                  mem_wr_ready;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    modport master (
        output rom_rd_ena, rom_address, mem_wr_valid, mem_wr_addr, mem_wr_data,
        input  rom_data, mem_wr_ready
    );

    modport slave (
        input  rom_rd_ena, rom_address, mem_wr_valid, mem_wr_addr, mem_wr_data,
        output rom_data, mem_wr_ready
    );
endinterface

// File: rtl/boot_loader.sv
// Copies NUM_WORDS words from the boot ROM to memory at DEST_BASE after reset,
// keeps a wrapping checksum, then releases the core by raising cpu_rst_n.
module boot_loader #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] NUM_WORDS  = 32'hFFF,
    parameter logic [ADDR_WIDTH-1:0] DEST_BASE  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    boot_loader_if.master         bus,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = NUM_WORDS - ADDR_WIDTH'(1);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  rom_rd_ena_q;
    logic [ADDR_WIDTH-1:0] rom_address_q;
    logic                  mem_wr_valid_q;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_q;
    logic [DATA_WIDTH-1:0] mem_wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] checksum_q;
    logic                  cpu_rst_n_q;

    // Copy sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            rom_rd_ena_q   <= 1'b0;
            rom_address_q  <= '0;
            mem_wr_valid_q <= 1'b0;
            mem_wr_addr_q  <= '0;
            mem_wr_data_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            checksum_q     <= '0;
            cpu_rst_n_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_FETCH;
                        busy_q        <= 1'b1;
                        rom_rd_ena_q  <= 1'b1;
                        rom_address_q <= idx_q;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    rom_rd_ena_q <= 1'b0;
                    state_q      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    // ROM data register is valid now; it is consumed here and never held.
                    mem_wr_data_q  <= bus.rom_data;
                    mem_wr_addr_q  <= DEST_BASE + {idx_q[ADDR_WIDTH-3:0], 2'b00};
                    mem_wr_valid_q <= 1'b1;
                    state_q        <= S_WRITE;
                end
                S_WRITE: begin
                    if (bus.mem_wr_ready) begin
                        mem_wr_valid_q <= 1'b0;
                        checksum_q     <= checksum_q + mem_wr_data_q;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q         <= idx_q + ADDR_WIDTH'(1);
                            rom_rd_ena_q  <= 1'b1;
                            rom_address_q <= idx_q + ADDR_WIDTH'(1);
                            state_q       <= S_FETCH;
                        end
                    end else begin
                        state_q <= S_WRITE;
                    end
                end
                S_DONE: begin
                    // Terminal: only rst_n leaves this state.
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    cpu_rst_n_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                default: begin
                    state_q        <= S_IDLE;
                    rom_rd_ena_q   <= 1'b0;
                    mem_wr_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_rd_ena   = rom_rd_ena_q;
    assign bus.rom_address  = rom_address_q;
    assign bus.mem_wr_valid = mem_wr_valid_q;
    assign bus.mem_wr_addr  = mem_wr_addr_q;
    assign bus.mem_wr_data  = mem_wr_data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign checksum         = checksum_q;
    assign cpu_rst_n        = cpu_rst_n_q;

endmodule
